// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding and default parameters for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IBUSY = 2'b01,
    ST_DBUSY = 2'b10
  } arbState_t;
  localparam int DEF_TIMEOUT = 16;
  localparam logic [31:0] DEF_ERR_DATA = 32'h0000_0000;
endpackage

// File: rtl/mem_port_arbiter_ctr.sv
// arb_timeout_ctr: saturating watchdog counter with clear, enable and expiry at TIMEOUT-1
module arb_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset | clr) cnt <= '0;
    else if (en & ~expired) cnt <= cnt + 1'b1;
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports with a watchdog
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic        IWait,
  output logic        DWait,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic        MemErr
);
  arbState_t state, stateNext;
  logic busy, grantD, grantI, ack, expire, finish, ctrClr, ctrEn, expired;
  logic [31:0] endRdata;
  assign IWait = IReq & ~IReady;
  assign DWait = DReq & ~DReady;
  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) uCtr (
    .clk(clk), .reset(reset), .clr(ctrClr), .en(ctrEn), .expired(expired)
  );
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= stateNext;
  // a port whose Ready is high this cycle is not eligible, which forces fetch in between data bursts
  always_comb begin
    busy = state != ST_IDLE;
    grantD = ~busy & DWait;
    grantI = ~busy & ~DWait & IWait;
    ack = busy & MemAck;
    expire = busy & ~MemAck & expired;
    finish = ack | expire;
    ctrClr = grantD | grantI;
    ctrEn = busy & ~MemAck;
    endRdata = ack ? MemRdata : ERR_DATA;
    stateNext = grantD ? ST_DBUSY : grantI ? ST_IBUSY : finish ? ST_IDLE : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      MemReq <= 1'b0;
      MemWe <= 1'b0;
      MemAddr <= '0;
      MemWdata <= '0;
      IReady <= 1'b0;
      DReady <= 1'b0;
      IRdata <= '0;
      DRdata <= '0;
      MemErr <= 1'b0;
    end else begin
      IReady <= finish & (state == ST_IBUSY);
      DReady <= finish & (state == ST_DBUSY);
      MemErr <= expire;
      if (grantD | grantI) begin
        MemReq <= 1'b1;
        MemWe <= grantD & DWe;
        MemAddr <= grantD ? DAddr : IAddr;
        MemWdata <= grantD ? DWdata : '0;
      end else if (finish) MemReq <= 1'b0;
      if (finish & (state == ST_IBUSY)) IRdata <= endRdata;
      if (finish & (state == ST_DBUSY)) DRdata <= endRdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, hold, watchdog and reset behaviour
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic IReq = 0, DReq = 0, DWe = 0, MemAck = 0;
  logic [31:0] IAddr = 0, DAddr = 0, DWdata = 0, MemRdata = 0;
  logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
  logic IReady, DReady, IWait, DWait, MemReq, MemWe, MemErr;
  logic [31:0] t4IRdata, t4DRdata, t4MemAddr, t4MemWdata;
  logic t4IReady, t4DReady, t4IWait, t4DWait, t4MemReq, t4MemWe, t4MemErr;
  int nCmp = 0, nErr = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset), .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata), .DReady(DReady),
    .IWait(IWait), .DWait(DWait), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck), .MemErr(MemErr)
  );
  mem_port_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut4 (
    .clk(clk), .reset(reset), .IReq(IReq), .IAddr(IAddr), .IRdata(t4IRdata), .IReady(t4IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(t4DRdata), .DReady(t4DReady),
    .IWait(t4IWait), .DWait(t4DWait), .MemReq(t4MemReq), .MemWe(t4MemWe), .MemAddr(t4MemAddr),
    .MemWdata(t4MemWdata), .MemRdata(MemRdata), .MemAck(MemAck), .MemErr(t4MemErr)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chkZero(input string tag);
    chk({tag, ".MemReq"}, MemReq, 0);
    chk({tag, ".MemWe"}, MemWe, 0);
    chk({tag, ".MemAddr"}, MemAddr, 0);
    chk({tag, ".MemWdata"}, MemWdata, 0);
    chk({tag, ".IReady"}, IReady, 0);
    chk({tag, ".DReady"}, DReady, 0);
    chk({tag, ".IRdata"}, IRdata, 0);
    chk({tag, ".DRdata"}, DRdata, 0);
    chk({tag, ".MemErr"}, MemErr, 0);
  endtask
  initial begin
    tick;
    tick;
    chkZero("rst");
    reset = 0;
    // fetch alone, ack one cycle after MemReq rises
    IReq = 1; IAddr = 32'h40;
    tick;
    chk("f.req", MemReq, 1); chk("f.addr", MemAddr, 32'h40); chk("f.we", MemWe, 0); chk("f.wait", IWait, 1);
    tick;
    chk("f.hold", MemReq, 1); chk("f.noRdy", IReady, 0);
    MemAck = 1; MemRdata = 32'hE3A0_0001;
    tick;
    chk("f.rdy", IReady, 1); chk("f.data", IRdata, 32'hE3A0_0001); chk("f.drop", MemReq, 0);
    chk("f.we2", MemWe, 0); chk("f.waitLo", IWait, 0);
    IReq = 0; MemAck = 0;
    tick;
    chk("f.pulse", IReady, 0); chk("f.idle", MemReq, 0);
    // simultaneous requests: data first, fetch granted in the DReady cycle
    IReq = 1; IAddr = 32'h44; DReq = 1; DWe = 0; DAddr = 32'h100;
    tick;
    chk("b.dfirst", MemAddr, 32'h100); chk("b.req", MemReq, 1); chk("b.we", MemWe, 0);
    MemAck = 1; MemRdata = 32'h1234;
    tick;
    chk("b.drdy", DReady, 1); chk("b.ddata", DRdata, 32'h1234); chk("b.drop", MemReq, 0); chk("b.iwait", IWait, 1);
    MemAck = 0; DReq = 0;
    tick;
    chk("b.igrant", MemAddr, 32'h44); chk("b.ireq", MemReq, 1); chk("b.dpulse", DReady, 0);
    MemAck = 1; MemRdata = 32'h5555;
    tick;
    chk("b.irdy", IReady, 1); chk("b.idata", IRdata, 32'h5555);
    IReq = 0; MemAck = 0;
    tick;
    // back-to-back stores with fetch pending: fetch interleaves every time
    DReq = 1; DWe = 1; IReq = 1; IAddr = 32'h48; MemAck = 1;
    for (int i = 0; i < 3; i++) begin
      DAddr = 32'h300 + 32'(i * 4); DWdata = 32'hA0 + 32'(i);
      tick;
      chk("s.daddr", MemAddr, 32'h300 + 32'(i * 4)); chk("s.we", MemWe, 1); chk("s.wd", MemWdata, 32'hA0 + 32'(i));
      tick;
      chk("s.drdy", DReady, 1); chk("s.noI", IReady, 0);
      tick;
      chk("s.iaddr", MemAddr, 32'h48); chk("s.iwe", MemWe, 0); chk("s.ireq", MemReq, 1);
      tick;
      chk("s.irdy", IReady, 1); chk("s.noD", DReady, 0);
    end
    DReq = 0; IReq = 0; MemAck = 0;
    tick;
    chk("s.idle", MemReq, 0);
    // slow store: request fields held for six cycles
    DReq = 1; DWe = 1; DAddr = 32'h200; DWdata = 32'hCAFE_F00D;
    tick;
    for (int j = 1; j <= 6; j++) begin
      chk("d.req", MemReq, 1); chk("d.addr", MemAddr, 32'h200); chk("d.wd", MemWdata, 32'hCAFE_F00D);
      chk("d.we", MemWe, 1); chk("d.wait", DWait, 1); chk("d.noRdy", DReady, 0);
      if (j == 6) MemAck = 1;
      tick;
    end
    chk("d.rdy", DReady, 1); chk("d.waitLo", DWait, 0); chk("d.drop", MemReq, 0); chk("d.noErr", MemErr, 0);
    DReq = 0; MemAck = 0;
    // watchdog on the TIMEOUT=4 instance
    reset = 1;
    tick;
    reset = 0;
    DReq = 1; DWe = 0; DAddr = 32'h10;
    tick;
    for (int k = 1; k <= 4; k++) begin
      chk("w.req", t4MemReq, 1); chk("w.noErr", t4MemErr, 0); chk("w.noRdy", t4DReady, 0);
      tick;
    end
    chk("w.err", t4MemErr, 1); chk("w.rdy", t4DReady, 1); chk("w.data", t4DRdata, 32'hDEAD_BEEF); chk("w.drop", t4MemReq, 0);
    DReq = 0;
    tick;
    chk("w.errPulse", t4MemErr, 0); chk("w.idle", t4MemReq, 0); chk("w.rdyPulse", t4DReady, 0);
    // reset mid-transaction, then a late ack
    reset = 1;
    tick;
    reset = 0;
    DReq = 1; DWe = 1; DAddr = 32'h400; DWdata = 32'h77;
    tick;
    chk("r.busy", MemReq, 1);
    tick;
    reset = 1;
    tick;
    chkZero("r.rst");
    reset = 0; DReq = 0; MemAck = 1; MemRdata = 32'h9999;
    tick;
    chk("r.lateRdy", DReady, 0); chk("r.lateReq", MemReq, 0); chk("r.lateData", DRdata, 0);
    MemAck = 0;
    tick;
    chk("r.quiet", DReady, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
